// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults, unknown-latency code and lane slicing helper
package hazard_pkg;
    localparam int LANES_DEF = 2;
    localparam int NREGS_DEF = 32;
    localparam int RA_W_DEF  = 5;
    localparam int LAT_W_DEF = 3;
    localparam int CNT_W_DEF = 16;
    localparam logic [LAT_W_DEF-1:0] LAT_UNKNOWN = '1;

    function automatic int lsb(input int lane, input int w);
        return lane * w;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode bundle, completion ports and issue/stall results
interface hazard_scoreboard_if #(
    parameter int LANES = hazard_pkg::LANES_DEF,
    parameter int NREGS = hazard_pkg::NREGS_DEF,
    parameter int RA_W  = hazard_pkg::RA_W_DEF,
    parameter int LAT_W = hazard_pkg::LAT_W_DEF,
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
);
    logic [LANES-1:0]       dec_valid;
    logic [LANES*RA_W-1:0]  dec_rs;
    logic [LANES*RA_W-1:0]  dec_rt;
    logic [LANES*RA_W-1:0]  dec_rd;
    logic [LANES-1:0]       dec_we;
    logic [LANES*LAT_W-1:0] dec_lat;
    logic                   ex_ready;
    logic                   flush;
    logic [LANES-1:0]       wb_clr_valid;
    logic [LANES*RA_W-1:0]  wb_clr_rd;
    logic [LANES-1:0]       issue_mask;
    logic                   stalld;
    logic                   split;
    logic [NREGS-1:0]       busy_vec;
    logic [CNT_W-1:0]       stall_cnt;

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rd, dec_we, dec_lat, ex_ready, flush,
               wb_clr_valid, wb_clr_rd,
        output issue_mask, stalld, split, busy_vec, stall_cnt
    );
    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rd, dec_we, dec_lat, ex_ready, flush,
               wb_clr_valid, wb_clr_rd,
        input  issue_mask, stalld, split, busy_vec, stall_cnt
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's pending-write countdown (set > clear > decrement)
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_i,
    input  logic [LAT_W-1:0] lat_i,
    input  logic             clr_i,
    output logic             busy_o
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // all-ones means unknown latency: hold until a completion clears it
    always_comb cnt_d = set_i ? lat_i :
                        clr_i ? '0 :
                        (cnt_q != '0 && cnt_q != {LAT_W{1'b1}}) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign busy_o = cnt_q != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard check producing an in-order issue mask and stall
module hazard_scoreboard #(
    parameter int LANES = hazard_pkg::LANES_DEF,
    parameter int NREGS = hazard_pkg::NREGS_DEF,
    parameter int RA_W  = hazard_pkg::RA_W_DEF,
    parameter int LAT_W = hazard_pkg::LAT_W_DEF,
    parameter int CNT_W = hazard_pkg::CNT_W_DEF
) (
    input logic clk,
    input logic reset_n,
    hazard_scoreboard_if.slave bus
);
    import hazard_pkg::*;

    logic [RA_W-1:0]  rs [LANES];
    logic [RA_W-1:0]  rt [LANES];
    logic [RA_W-1:0]  rd [LANES];
    logic [RA_W-1:0]  clr_rd [LANES];
    logic [LAT_W-1:0] lat [LANES];
    logic [NREGS-1:0] busy;
    logic [LANES-1:0] haz, mask;
    logic             go, stalld;
    logic [CNT_W-1:0] stall_q, stall_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign rs[l]     = bus.dec_rs[lsb(l, RA_W) +: RA_W];
        assign rt[l]     = bus.dec_rt[lsb(l, RA_W) +: RA_W];
        assign rd[l]     = bus.dec_rd[lsb(l, RA_W) +: RA_W];
        assign clr_rd[l] = bus.wb_clr_rd[lsb(l, RA_W) +: RA_W];
        assign lat[l]    = bus.dec_lat[lsb(l, LAT_W) +: LAT_W];
    end

    // busy[0] is constant zero, so r0 sources never raise a scoreboard hazard
    always_comb begin
        haz = '0;
        for (int i = 0; i < LANES; i++) begin
            haz[i] = busy[rs[i]] | busy[rt[i]] | (bus.dec_we[i] & busy[rd[i]]);
            for (int j = 0; j < i; j++)
                if (bus.dec_valid[j] && bus.dec_we[j] && rd[j] != '0 &&
                    (rd[j] == rs[i] || rd[j] == rt[i] || (bus.dec_we[i] && rd[j] == rd[i])))
                    haz[i] = 1'b1;
        end
    end

    always_comb begin
        mask = '0;
        go = bus.ex_ready & ~bus.flush;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = go & bus.dec_valid[i] & ~haz[i];
            go = mask[i];
        end
    end

    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ent
        logic             set, clr;
        logic [LAT_W-1:0] set_lat;
        always_comb begin
            set = 1'b0;
            clr = 1'b0;
            set_lat = '0;
            for (int i = 0; i < LANES; i++) begin
                if (mask[i] && bus.dec_we[i] && rd[i] == RA_W'(r) && lat[i] != '0) begin
                    set = 1'b1;
                    set_lat = lat[i];
                end
                if (bus.wb_clr_valid[i] && clr_rd[i] == RA_W'(r)) clr = 1'b1;
            end
        end
        hazard_sb_entry #(.LAT_W(LAT_W)) u_ent (
            .clk    (clk),
            .reset_n(reset_n),
            .set_i  (set),
            .lat_i  (set_lat),
            .clr_i  (clr),
            .busy_o (busy[r])
        );
    end

    assign stalld  = bus.dec_valid[0] & ~mask[0] & ~bus.flush;
    assign stall_d = (stalld && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) stall_q <= '0;
        else stall_q <= stall_d;

    assign bus.issue_mask = mask;
    assign bus.stalld     = stalld;
    assign bus.split      = |mask & (mask != bus.dec_valid);
    assign bus.busy_vec   = busy;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: queue-based scoreboard against a ready-cycle reference model
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int L = 2, NR = 32, RW = 5, LW = 3, CW = 8;
    localparam int INF = 1 << 30;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [L-1:0]  mask;
        logic          stalld;
        logic          split;
        logic [NR-1:0] busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.LANES(L), .NREGS(NR), .RA_W(RW), .LAT_W(LW), .CNT_W(CW)) bus ();
    hazard_scoreboard #(.LANES(L), .NREGS(NR), .RA_W(RW), .LAT_W(LW), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   ready_at[NR];
    int   cyc = 0, stalls = 0;
    bit   v[L], we[L], cv[L];
    int   rs[L], rt[L], rd[L], lat[L], crd[L];
    bit   er, fl;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", n, $time, a, x);
        end
    endtask

    // a register is busy until the cycle at which its result becomes forwardable
    function automatic bit busy_r(input int r);
        return r != 0 && ready_at[r] > cyc;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit ok, haz;
        logic [L-1:0] vv;
        e.mask = '0;
        ok = er && !fl;
        for (int i = 0; i < L; i++) begin
            vv[i] = v[i];
            haz = busy_r(rs[i]) || busy_r(rt[i]) || (we[i] && busy_r(rd[i]));
            for (int j = 0; j < i; j++)
                if (v[j] && we[j] && rd[j] != 0 &&
                    (rd[j] == rs[i] || rd[j] == rt[i] || (we[i] && rd[j] == rd[i]))) haz = 1;
            ok = ok && v[i] && !haz;
            e.mask[i] = ok;
        end
        e.stalld = v[0] && !e.mask[0] && !fl;
        e.split  = (e.mask != 0) && (e.mask != vv);
        for (int r = 0; r < NR; r++) e.busy[r] = busy_r(r);
        e.cnt = CW'(stalls > CMAX ? CMAX : stalls);
        return e;
    endfunction

    task automatic pack();
        for (int i = 0; i < L; i++) begin
            bus.dec_valid[i]           = v[i];
            bus.dec_we[i]              = we[i];
            bus.dec_rs[i*RW +: RW]     = RW'(rs[i]);
            bus.dec_rt[i*RW +: RW]     = RW'(rt[i]);
            bus.dec_rd[i*RW +: RW]     = RW'(rd[i]);
            bus.dec_lat[i*LW +: LW]    = LW'(lat[i]);
            bus.wb_clr_valid[i]        = cv[i];
            bus.wb_clr_rd[i*RW +: RW]  = RW'(crd[i]);
        end
        bus.ex_ready = er;
        bus.flush    = fl;
    endtask

    task automatic idle();
        for (int i = 0; i < L; i++) begin
            v[i] = 0; we[i] = 0; cv[i] = 0;
            rs[i] = 0; rt[i] = 0; rd[i] = 0; lat[i] = 0; crd[i] = 0;
        end
        er = 1; fl = 0;
    endtask

    task automatic lane(input int i, input int d, input int a, input int b, input bit w, input int lt);
        v[i] = 1; rd[i] = d; rs[i] = a; rt[i] = b; we[i] = w; lat[i] = lt;
    endtask

    task automatic step();
        exp_t e;
        bit setr[NR];
        pack();
        e = predict();
        q.push_back(e);
        @(posedge clk);
        for (int r = 0; r < NR; r++) setr[r] = 0;
        for (int i = 0; i < L; i++)
            if (e.mask[i] && we[i] && rd[i] != 0 && lat[i] != 0) begin
                setr[rd[i]] = 1;
                ready_at[rd[i]] = (lat[i] == int'(LAT_UNKNOWN)) ? INF : cyc + lat[i] + 1;
            end
        for (int i = 0; i < L; i++)
            if (cv[i] && !setr[crd[i]] && ready_at[crd[i]] > cyc + 1) ready_at[crd[i]] = cyc + 1;
        stalls += int'(e.stalld);
        cyc++;
        #1;
    endtask

    task automatic async_reset();
        #1;
        idle();
        lane(0, 1, 2, 3, 1, 0);
        pack();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy_vec), 0);
        chk("rst_cnt", 64'(bus.stall_cnt), 0);
        chk("rst_mask", 64'(bus.issue_mask), 1);
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        stalls = 0;
        idle();
        pack();
        #1 reset_n = 1'b1;
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("issue_mask", 64'(bus.issue_mask), 64'(e.mask));
            chk("stalld", 64'(bus.stalld), 64'(e.stalld));
            chk("split", 64'(bus.split), 64'(e.split));
            chk("busy_vec", 64'(bus.busy_vec), 64'(e.busy));
            chk("stall_cnt", 64'(bus.stall_cnt), 64'(e.cnt));
        end

    initial begin
        for (int r = 0; r < NR; r++) ready_at[r] = 0;
        idle();
        pack();
        #12;
        chk("init_busy", 64'(bus.busy_vec), 0);
        chk("init_cnt", 64'(bus.stall_cnt), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        // independent pair, then intra-bundle RAW split and re-presentation
        idle(); lane(0, 1, 3, 4, 1, 0); lane(1, 2, 5, 6, 1, 0); step();
        idle(); lane(0, 5, 1, 2, 1, 0); lane(1, 8, 5, 0, 1, 0); step();
        idle(); lane(0, 8, 5, 0, 1, 0); step();
        // load with latency 2 and its consumer
        idle(); lane(0, 7, 1, 2, 1, 2); step();
        repeat (3) begin idle(); lane(0, 11, 7, 0, 1, 0); step(); end
        // unknown latency released by a completion
        idle(); lane(0, 9, 1, 2, 1, 7); step();
        repeat (9) begin idle(); lane(0, 12, 9, 0, 1, 0); step(); end
        idle(); lane(0, 12, 9, 0, 1, 0); cv[0] = 1; crd[0] = 9; step();
        idle(); lane(0, 12, 9, 0, 1, 0); step();
        idle(); lane(0, 9, 1, 2, 1, 7); cv[1] = 1; crd[1] = 9; step();
        idle(); step();
        idle(); cv[0] = 1; crd[0] = 9; step();
        idle(); cv[1] = 1; crd[1] = 13; step();
        // r0 destination, flush, and ex_ready low
        idle(); lane(0, 0, 1, 2, 1, 3); step();
        idle(); lane(0, 14, 0, 0, 1, 0); step();
        idle(); lane(0, 10, 1, 2, 1, 3); lane(1, 15, 3, 4, 1, 2); fl = 1; step();
        idle(); lane(0, 10, 1, 2, 1, 3); er = 0; step();
        idle(); lane(0, 16, 10, 15, 1, 0); step();
        // reset while r7 counts down
        idle(); lane(0, 7, 1, 2, 1, 2); step();
        chk("pre_rst_busy7", 64'(bus.busy_vec[7]), 1);
        async_reset();
        idle(); step();
        // stall counter saturation
        idle(); lane(0, 1, 2, 3, 1, 7); step();
        repeat (CMAX + 20) begin idle(); lane(0, 2, 1, 0, 1, 0); step(); end
        idle(); cv[0] = 1; crd[0] = 1; step();
        idle(); step();
        async_reset();
        // randomized traffic on a small register window to provoke hazards
        repeat (400) begin
            idle();
            for (int i = 0; i < L; i++) begin
                v[i] = ($urandom % 4) != 0;
                we[i] = ($urandom % 4) != 0;
                rs[i] = $urandom % 8;
                rt[i] = $urandom % 8;
                rd[i] = $urandom % 8;
                lat[i] = $urandom % 8;
                cv[i] = ($urandom % 5) == 0;
                crd[i] = $urandom % 8;
            end
            er = ($urandom % 8) != 0;
            fl = ($urandom % 12) == 0;
            step();
        end
        idle();
        pack();
        #10;
        chk("drain", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
